// File: rtl/mem_router.sv
// Single-master to N-slave memory router: address decode, latched slave-side request,
// per-transfer ack timeout and a saturating error counter.
module mem_router #(
  parameter int unsigned            N_SLV    = 3,
  parameter logic [32*N_SLV-1:0]    SLV_BASE = {32'h1000_0010, 32'h1000_0000, 32'h0000_0000},
  parameter logic [32*N_SLV-1:0]    SLV_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_0000},
  parameter int unsigned            TIMEOUT  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           be,
  output logic                 ready,
  output logic [31:0]          rdata,
  output logic                 err,
  output logic [N_SLV-1:0]     s_en,
  output logic                 s_we,
  output logic [31:0]          s_addr,
  output logic [31:0]          s_wdata,
  output logic [3:0]           s_be,
  input  logic [32*N_SLV-1:0]  s_rdata,
  input  logic [N_SLV-1:0]     s_ack,
  output logic [15:0]          err_cnt
);

  localparam int unsigned SelW      = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam logic [7:0]  TimeoutM1 = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e              state_q, state_d;
  logic [SelW-1:0]     sel_q;
  logic                hit_q;
  logic [7:0]          wait_q;
  logic                ready_q, err_q, s_we_q;
  logic [31:0]         rdata_q, s_addr_q, s_wdata_q;
  logic [3:0]          s_be_q;
  logic [N_SLV-1:0]    s_en_q;
  logic [15:0]         err_cnt_q;

  logic                dec_hit;
  logic [SelW-1:0]     dec_idx;
  logic [N_SLV-1:0]    dec_onehot;
  logic                ack_sel;
  logic                timed_out;
  logic [31:0]         sel_rdata;

  // Scan from the top index down so the lowest matching slave is the last to be written.
  always_comb begin
    dec_hit    = 1'b0;
    dec_idx    = '0;
    dec_onehot = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        dec_hit       = 1'b1;
        dec_idx       = SelW'(i);
        dec_onehot    = '0;
        dec_onehot[i] = 1'b1;
      end
    end
  end

  assign ack_sel   = hit_q & s_ack[sel_q];
  assign timed_out = (wait_q == TimeoutM1);
  assign sel_rdata = s_rdata[32*sel_q +: 32];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req) state_d = dec_hit ? StAccess : StDone;
      StAccess: if (ack_sel || timed_out) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      hit_q     <= 1'b0;
      wait_q    <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      s_en_q    <= '0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_be_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == StDone);
      unique case (state_q)
        StIdle: begin
          if (req) begin
            s_addr_q  <= addr;
            s_wdata_q <= wdata;
            s_we_q    <= we;
            s_be_q    <= be;
            sel_q     <= dec_idx;
            hit_q     <= dec_hit;
            wait_q    <= '0;
            s_en_q    <= dec_onehot;
            if (!dec_hit) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        StAccess: begin
          // Ack wins over a timeout landing in the same cycle.
          if (ack_sel) begin
            rdata_q <= s_we_q ? 32'h0 : sel_rdata;
            err_q   <= 1'b0;
            s_en_q  <= '0;
          end else if (timed_out) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            s_en_q  <= '0;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StDone: begin
          if (err_q && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign ready   = ready_q;
  assign rdata   = rdata_q;
  assign err     = err_q;
  assign s_en    = s_en_q;
  assign s_we    = s_we_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_be    = s_be_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_mem_router.sv
// Scoreboard bench for mem_router: stimulus pushes expected {rdata, err}; a monitor pops on ready.
module tb_mem_router;

  logic        clk, rst, req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        ready, err;
  logic [31:0] rdata, s_addr, s_wdata;
  logic [2:0]  s_en, s_ack, s_ack_man;
  logic        s_we;
  logic [3:0]  s_be;
  logic [95:0] s_rdata;
  logic [15:0] err_cnt;
  logic        auto_ack;

  int total = 0;
  int bad = 0;
  int ready_cnt = 0;
  logic [32:0] sb[$];

  mem_router dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready), .rdata(rdata), .err(err), .s_en(s_en), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_be(s_be), .s_rdata(s_rdata), .s_ack(s_ack), .err_cnt(err_cnt)
  );

  // Slave model: either hand-driven acks or every selected slave acks immediately.
  assign s_ack = auto_ack ? s_en : s_ack_man;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      ready_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got rdata=%h err=%b want no response", rdata, err);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        check("resp_rdata", rdata, e[32:1]);
        check("resp_err", {31'h0, err}, {31'h0, e[0]});
      end
    end
  end

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    s_rdata = '0; s_ack_man = '0; auto_ack = 1'b0;
    tick(); tick();
    check("rst_s_en", {29'h0, s_en}, 32'h0);
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_err_cnt", {16'h0, err_cnt}, 32'h0);
    rst = 1'b0;
    tick();

    // Read slave 0, ack in first ACCESS cycle
    req = 1'b1; we = 1'b0; addr = 32'h0000_0040; s_rdata[31:0] = 32'hCAFE_0001;
    sb.push_back({32'hCAFE_0001, 1'b0});
    tick();
    req = 1'b0;
    check("rd0_s_en", {29'h0, s_en}, 32'h1);
    check("rd0_s_addr", s_addr, 32'h0000_0040);
    s_ack_man = 3'b001;
    tick();
    s_ack_man = '0;
    check("rd0_done_s_en", {29'h0, s_en}, 32'h0);
    check("rd0_ready", {31'h0, ready}, 32'h1);
    tick();

    // Write slave 1, ack after 3 wait cycles
    req = 1'b1; we = 1'b1; addr = 32'h1000_0004; wdata = 32'h0000_00A5; be = 4'hF;
    sb.push_back({32'h0, 1'b0});
    tick();
    req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("wr1_s_en", {29'h0, s_en}, 32'h2);
      if (k == 0) begin
        check("wr1_s_we", {31'h0, s_we}, 32'h1);
        check("wr1_s_wdata", s_wdata, 32'h0000_00A5);
        check("wr1_s_be", {28'h0, s_be}, 32'hF);
      end
      s_ack_man = (k == 3) ? 3'b010 : 3'b000;
      tick();
    end
    s_ack_man = '0;
    check("wr1_done_s_en", {29'h0, s_en}, 32'h0);
    tick();

    // Unmapped address
    req = 1'b1; we = 1'b0; addr = 32'h2000_0000;
    sb.push_back({32'h0, 1'b1});
    tick();
    req = 1'b0;
    check("miss_s_en", {29'h0, s_en}, 32'h0);
    check("miss_ready", {31'h0, ready}, 32'h1);
    tick();
    check("miss_err_cnt", {16'h0, err_cnt}, 32'h1);

    // Timeout on slave 2 with a spurious ack from slave 0
    req = 1'b1; addr = 32'h1000_0010; s_rdata[95:64] = 32'hDEAD_BEEF;
    sb.push_back({32'h0, 1'b1});
    tick();
    req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("to_s_en", {29'h0, s_en}, 32'h4);
      s_ack_man = (k == 5) ? 3'b001 : 3'b000;
      tick();
    end
    s_ack_man = '0;
    check("to_done_s_en", {29'h0, s_en}, 32'h0);
    check("to_ready", {31'h0, ready}, 32'h1);
    tick();
    check("to_err_cnt", {16'h0, err_cnt}, 32'h2);

    // Reset in the 2nd ACCESS cycle of a slave-1 read
    req = 1'b1; we = 1'b0; addr = 32'h1000_0008; s_rdata[63:32] = 32'h1111_2222;
    tick();
    req = 1'b0;
    check("abort_acc1_s_en", {29'h0, s_en}, 32'h2);
    tick();
    check("abort_acc2_s_en", {29'h0, s_en}, 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_s_en", {29'h0, s_en}, 32'h0);
    check("abort_ready", {31'h0, ready}, 32'h0);
    check("abort_err", {31'h0, err}, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    check("abort_s_addr", s_addr, 32'h0);
    check("abort_s_wdata", s_wdata, 32'h0);
    check("abort_s_be", {28'h0, s_be}, 32'h0);
    check("abort_err_cnt", {16'h0, err_cnt}, 32'h0);
    tick();
    req = 1'b1; addr = 32'h0000_0100; s_rdata[31:0] = 32'h1234_5678;
    sb.push_back({32'h1234_5678, 1'b0});
    tick();
    req = 1'b0;
    check("post_rst_s_en", {29'h0, s_en}, 32'h1);
    s_ack_man = 3'b001;
    tick();
    s_ack_man = '0;
    check("post_rst_ready", {31'h0, ready}, 32'h1);
    tick();

    // Back-to-back reads with req held high
    auto_ack = 1'b1;
    req = 1'b1; addr = 32'h0000_0200;
    s_rdata[31:0] = 32'hAAAA_0000; s_rdata[95:64] = 32'hBBBB_0002;
    sb.push_back({32'hAAAA_0000, 1'b0});
    sb.push_back({32'hBBBB_0002, 1'b0});
    tick();
    check("b2b_a_s_en", {29'h0, s_en}, 32'h1);
    tick();
    check("b2b_a_ready", {31'h0, ready}, 32'h1);
    check("b2b_a_done_s_en", {29'h0, s_en}, 32'h0);
    addr = 32'h1000_0014;
    tick();
    check("b2b_idle_ready", {31'h0, ready}, 32'h0);
    check("b2b_idle_s_en", {29'h0, s_en}, 32'h0);
    tick();
    req = 1'b0;
    check("b2b_b_s_en", {29'h0, s_en}, 32'h4);
    check("b2b_b_s_addr", s_addr, 32'h1000_0014);
    tick();
    check("b2b_b_ready", {31'h0, ready}, 32'h1);
    tick();
    auto_ack = 1'b0;
    tick(); tick();

    check("sb_drained", sb.size(), 32'h0);
    check("ready_count", ready_cnt, 32'd7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
